// File: rtl/ks_serial_adder.sv
// WIDTH-bit adder built from one 4-bit Kogge-Stone adder, fed one nibble per
// cycle (LSB first) with the carry registered between nibbles.

module kogge_stone_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p, g1, g2;
  logic [3:1] p1;

  assign g = a & b;
  assign p = a ^ b;

  // cin is folded into bit 0's generate so the prefix tree needs no extra level.
  assign g1[0] = g[0] | (p[0] & cin);
  assign g1[1] = g[1] | (p[1] & g1[0]);
  assign g1[2] = g[2] | (p[2] & g[1]);
  assign g1[3] = g[3] | (p[3] & g[2]);
  assign p1[1] = p[1] & p[0];
  assign p1[2] = p[2] & p[1];
  assign p1[3] = p[3] & p[2];

  assign g2[0] = g1[0];
  assign g2[1] = g1[1];
  assign g2[2] = g1[2] | (p1[2] & g1[0]);
  assign g2[3] = g1[3] | (p1[3] & g1[1]);

  assign sum  = p ^ {g2[2:0], cin};
  assign cout = g2[3];
endmodule

module ks_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             msb_a_q, msb_b_q;
  logic [3:0]       ks_sum;
  logic             ks_cout;

  kogge_stone_adder_4bit u_ks (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (ks_sum),
    .cout (ks_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            idx_q   <= '0;
            msb_a_q <= a[WIDTH-1];
            msb_b_q <= b[WIDTH-1];
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          res_q[{idx_q, 2'b00} +: 4] <= ks_sum;
          carry_q <= ks_cout;
          a_sh_q  <= a_sh_q >> 4;
          b_sh_q  <= b_sh_q >> 4;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IW'(NIBBLES - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = res_q;
  assign cout      = carry_q;
  assign overflow  = (msb_a_q == msb_b_q) && (res_q[WIDTH-1] != msb_a_q);
  assign dbg_state = state_q;
endmodule
